universal_shift_register: RTL and testbench
===========================================

# universal_shift_register

Parametrised successor to the team's single-bit serial/parallel shift register. It shifts by LANE_W bits per step, and direction and fill mode are selected at run time: logical, rotate or arithmetic. It adds a valid/ready parallel-load handshake and an autonomous burst engine that performs N shifts with busy/done signalling. It sits between parallel datapaths and narrow serial links: SPI-like framers, bit-serial arithmetic, scan-style loaders.

## Interface
Parameters:
- WIDTH, 8, register width; WIDTH ≥ 2, WIDTH % LANE_W == 0
- LANE_W, 1, bits shifted per step; 1 ≤ LANE_W < WIDTH
- CNT_W, 8, width of burst_len and the internal down-counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- load_valid  in  1  parallel load request
- load_ready  out  1  load accepted when high; equals IDLE state
- load_data  in  WIDTH  parallel load value
- dir  in  1  0 = right (toward bit 0), 1 = left
- mode  in  2  0 logical, 1 rotate, 2 arithmetic, 3 reserved (treated as logical)
- step_en  in  1  single shift request, IDLE only
- burst_start  in  1  start burst of burst_len shifts, IDLE only
- burst_len  in  CNT_W  number of shifts in burst
- burst_abort  in  1  terminate running burst
- serial_in  in  LANE_W  fill lane for logical shifts
- serial_out  out  LANE_W  lane leaving next: right → parallel_out[LANE_W-1:0], left → parallel_out[WIDTH-1 -: LANE_W]
- parallel_out  out  WIDTH  register contents
- busy  out  1  high in SHIFT state
- done  out  1  one-cycle pulse after burst completion

## Operation
- FSM states: IDLE, SHIFT.
- IDLE requests, in priority order. Only the highest-priority asserted request acts in a cycle.
  - load_valid: register ← load_data.
  - burst_start: latch dir, mode and burst_len; go to SHIFT if burst_len ≠ 0. If burst_len = 0, pulse done next cycle with no shift and busy never high.
  - step_en: one shift using live dir/mode.
- Shift step, right:
  - logical: {serial_in, reg[WIDTH-1:LANE_W]}
  - rotate: {reg[LANE_W-1:0], reg[WIDTH-1:LANE_W]}
  - arithmetic: LANE_W copies of reg[WIDTH-1] fill the top lane
- Shift step, left (mirror of right):
  - logical: {reg[WIDTH-1-LANE_W:0], serial_in}
  - rotate: {reg[WIDTH-1-LANE_W:0], reg[WIDTH-1 -: LANE_W]}
  - arithmetic: zero fill
- SHIFT state:
  - Each cycle performs one shift with the latched dir/mode, sampling serial_in live, and decrements the counter.
  - On the edge performing the final shift (counter = 1): go to IDLE and set done for the following cycle.
- burst_abort in SHIFT: no shift on that edge, go to IDLE, done not pulsed. burst_abort is ignored in IDLE.
- load_valid, step_en and burst_start are ignored in SHIFT; load_ready = 0 there.
- serial_out uses the latched dir in SHIFT and the live dir in IDLE.
- Reset, including mid-burst: parallel_out = 0, state IDLE, counter = 0, busy = 0, done = 0, load_ready = 1 after release.

## Timing
- Load or step sampled at edge k: parallel_out updates after edge k (1-cycle latency).
- Burst of N ≥ 1 sampled at edge k:
  - busy high after edge k through edge k+N.
  - Shifts occur at edges k+1 … k+N.
  - done high for exactly the cycle after edge k+N.
- burst_len = 0 at edge k: done high for the cycle after edge k only.
- done and busy are never high simultaneously.
- A new burst_start may be accepted in the cycle done is high (back-to-back bursts).
- serial_out and load_ready are combinational from state/register/dir. All other outputs are registered.

## Structure
- Package shift_pkg holds:
  - typedef shift_mode_e (SHIFT_LOGICAL, SHIFT_ROTATE, SHIFT_ARITH, SHIFT_RSVD)
  - typedef shift_state_e (ST_IDLE, ST_SHIFT)
  - constants DIR_RIGHT = 0, DIR_LEFT = 1
- One combinational sub-module, shift_step_unit (WIDTH, LANE_W; inputs reg, dir, mode, serial_in; output next reg). The top module holds the FSM, counter and latches.
- Elaboration-time checks on the WIDTH/LANE_W constraints.

## Test plan
- WIDTH=8, LANE_W=1: load 0xA5, step right logical with serial_in=1 → 0xD2. serial_out is 1 before the step, 0 after.
- Rotate: load 0x81, step left rotate → 0x03. Step right rotate from 0x03 → 0x81.
- Arithmetic: load 0x80, burst right arithmetic burst_len=3 → 0xF0. busy is high 3 cycles, done pulses once the next cycle, and load_ready is 0 throughout busy.
- WIDTH=8, LANE_W=2: load 0x00, burst right logical len=4 with serial_in=2'b11 → 0xFF. Load 0xE4, burst right logical len=4 → serial_out sequence 0,1,2,3.
- Corner cases:
  - load_valid=1 with load_data=0x55 during busy: no load, and the burst completes unchanged.
  - burst_len=0: done pulses next cycle, busy stays 0, parallel_out unchanged.
  - Simultaneous load_valid + burst_start in IDLE: the load wins and the burst is ignored.
- Abort and reset: abort after 2 of 5 shifts on 0x80 right logical with serial_in=0 → 0x20, no done. rst_n low mid-burst → all outputs 0, IDLE. After release, a step works normally.

Source files
------------

// File: rtl/universal_shift_register_pkg.sv
// Purpose: shared types and constants for the universal shift register slice.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: shift_mode_e (fill mode), shift_state_e (burst FSM), direction constants.
package shift_pkg;

   typedef enum logic [1:0] {
      SHIFT_LOGICAL = 2'd0,
      SHIFT_ROTATE  = 2'd1,
      SHIFT_ARITH   = 2'd2,
      SHIFT_RSVD    = 2'd3   // behaves as logical
   } shift_mode_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } shift_state_e;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/universal_shift_register_step.sv
// Purpose: one LANE_W-bit shift step of a WIDTH-bit register (logical/rotate/arithmetic).
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to register reg_out.
// Ports: reg_in (current value), dir (0 right, 1 left), mode, serial_in (logical fill lane),
//        reg_out (value after one step).
module shift_step_unit
   import shift_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int LANE_W = 1
) (
   input  logic [WIDTH-1:0]  reg_in,
   input  logic              dir,
   input  shift_mode_e       mode,
   input  logic [LANE_W-1:0] serial_in,
   output logic [WIDTH-1:0]  reg_out
);

   logic [LANE_W-1:0] fill;

   // Lane entering the register at the vacated end.
   always_comb begin
      fill = serial_in;
      case (mode)
         SHIFT_ROTATE: fill = (dir == DIR_RIGHT) ? reg_in[LANE_W-1:0]
                                                 : reg_in[WIDTH-1 -: LANE_W];
         // Sign extension only makes sense moving right; left arithmetic zero-fills.
         SHIFT_ARITH:  fill = (dir == DIR_RIGHT) ? {LANE_W{reg_in[WIDTH-1]}}
                                                 : '0;
         default:      fill = serial_in;
      endcase
   end

   always_comb begin
      if (dir == DIR_RIGHT) reg_out = {fill, reg_in[WIDTH-1:LANE_W]};
      else                  reg_out = {reg_in[WIDTH-1-LANE_W:0], fill};
   end

endmodule

// File: rtl/universal_shift_register.sv
// Purpose: parametrised shift register with parallel load, single steps and counted bursts.
// Latency: load/step visible 1 cycle after the sampling edge; burst of N shifts on the N edges after start.
// Backpressure: load_ready low while a burst runs; load/step/burst_start requests are dropped then.
// Ports: load_valid/load_ready/load_data (parallel load), dir/mode (shift control),
//        step_en, burst_start/burst_len/burst_abort (burst engine), serial_in/serial_out (lanes),
//        parallel_out (contents), busy (burst running), done (one-cycle completion pulse).
module universal_shift_register
   import shift_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int LANE_W = 1,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [WIDTH-1:0]  load_data,
   input  logic              dir,
   input  logic [1:0]        mode,
   input  logic              step_en,
   input  logic              burst_start,
   input  logic [CNT_W-1:0]  burst_len,
   input  logic              burst_abort,
   input  logic [LANE_W-1:0] serial_in,
   output logic [LANE_W-1:0] serial_out,
   output logic [WIDTH-1:0]  parallel_out,
   output logic              busy,
   output logic              done
);

   // Elaboration-time parameter checks.
   if (WIDTH < 2) begin : g_chk_width
      $error("universal_shift_register: WIDTH must be >= 2");
   end
   if (LANE_W < 1 || LANE_W >= WIDTH) begin : g_chk_lane
      $error("universal_shift_register: LANE_W must satisfy 1 <= LANE_W < WIDTH");
   end
   if ((WIDTH % LANE_W) != 0) begin : g_chk_mod
      $error("universal_shift_register: WIDTH must be a multiple of LANE_W");
   end
   if (CNT_W < 1) begin : g_chk_cnt
      $error("universal_shift_register: CNT_W must be >= 1");
   end

   shift_state_e      state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic              lat_dir_q, lat_dir_d;
   shift_mode_e       lat_mode_q, lat_mode_d;
   logic              done_q, done_d;

   logic              step_dir;
   shift_mode_e       step_mode;
   logic [WIDTH-1:0]  step_out;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         data_q     <= '0;
         lat_dir_q  <= DIR_RIGHT;
         lat_mode_q <= SHIFT_LOGICAL;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         data_q     <= data_d;
         lat_dir_q  <= lat_dir_d;
         lat_mode_q <= lat_mode_d;
         done_q     <= done_d;
      end
   end

   // A running burst uses the controls captured at burst_start; single steps use live ones.
   always_comb begin
      step_dir  = (state_q == ST_SHIFT) ? lat_dir_q  : dir;
      step_mode = (state_q == ST_SHIFT) ? lat_mode_q : shift_mode_e'(mode);
   end

   shift_step_unit #(
      .WIDTH  (WIDTH),
      .LANE_W (LANE_W)
   ) u_step (
      .reg_in    (data_q),
      .dir       (step_dir),
      .mode      (step_mode),
      .serial_in (serial_in),
      .reg_out   (step_out)
   );

   // ---------------- next-state / datapath ----------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      data_d     = data_q;
      lat_dir_d  = lat_dir_q;
      lat_mode_d = lat_mode_q;
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Priority: load, then burst_start, then single step.
            if (load_valid) begin
               data_d = load_data;
            end else if (burst_start) begin
               lat_dir_d  = dir;
               lat_mode_d = shift_mode_e'(mode);
               if (burst_len != '0) begin
                  state_d = ST_SHIFT;
                  cnt_d   = burst_len;
               end else begin
                  // Empty burst: report completion without ever going busy.
                  done_d = 1'b1;
               end
            end else if (step_en) begin
               data_d = step_out;
            end
         end
         ST_SHIFT: begin
            if (burst_abort) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               data_d = step_out;
               cnt_d  = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      load_ready   = (state_q == ST_IDLE);
      busy         = (state_q == ST_SHIFT);
      done         = done_q;
      parallel_out = data_q;
      serial_out   = (step_dir == DIR_RIGHT) ? data_q[LANE_W-1:0]
                                             : data_q[WIDTH-1 -: LANE_W];
   end

endmodule

// File: tb/tb_universal_shift_register.sv
// Purpose: self-checking bench for universal_shift_register (LANE_W=1 and LANE_W=2 instances).
// Latency: n/a.
// Backpressure: n/a.
module tb_universal_shift_register;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------- instance A: WIDTH=8, LANE_W=1 ----------
   logic       load_valid, load_ready, dir, step_en, burst_start, burst_abort, busy, done;
   logic [7:0] load_data, parallel_out, burst_len;
   logic [1:0] mode;
   logic       serial_in, serial_out;

   universal_shift_register #(.WIDTH(8), .LANE_W(1), .CNT_W(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
      .dir(dir), .mode(mode), .step_en(step_en),
      .burst_start(burst_start), .burst_len(burst_len), .burst_abort(burst_abort),
      .serial_in(serial_in), .serial_out(serial_out),
      .parallel_out(parallel_out), .busy(busy), .done(done)
   );

   // ---------- instance B: WIDTH=8, LANE_W=2 ----------
   logic       load_valid2, load_ready2, dir2, step_en2, burst_start2, burst_abort2, busy2, done2;
   logic [7:0] load_data2, parallel_out2, burst_len2;
   logic [1:0] mode2, serial_in2, serial_out2;

   universal_shift_register #(.WIDTH(8), .LANE_W(2), .CNT_W(8)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .load_valid(load_valid2), .load_ready(load_ready2), .load_data(load_data2),
      .dir(dir2), .mode(mode2), .step_en(step_en2),
      .burst_start(burst_start2), .burst_len(burst_len2), .burst_abort(burst_abort2),
      .serial_in(serial_in2), .serial_out(serial_out2),
      .parallel_out(parallel_out2), .busy(busy2), .done(done2)
   );

   typedef struct {
      string      name;
      logic       lv;
      logic [7:0] ld;
      logic       dr;
      logic [1:0] md;
      logic       st;
      logic       si;
      logic [7:0] exp_po;
      logic       exp_so;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      load_valid = 0; step_en = 0; burst_start = 0; burst_abort = 0;
   endtask

   task automatic do_load(input logic [7:0] v);
      load_valid = 1; load_data = v;
      tick();
      load_valid = 0;
   endtask

   initial begin
      // Single-cycle operations: {load, data, dir, mode, step, serial_in} -> {parallel_out, serial_out}
      vecs[0] = '{"load_a5",        1, 8'hA5, 0, 2'd0, 0, 0, 8'hA5, 1};
      vecs[1] = '{"r_logic_si1",    0, 8'h00, 0, 2'd0, 1, 1, 8'hD2, 0};
      vecs[2] = '{"load_81",        1, 8'h81, 1, 2'd0, 0, 0, 8'h81, 1};
      vecs[3] = '{"l_rotate",       0, 8'h00, 1, 2'd1, 1, 0, 8'h03, 0};
      vecs[4] = '{"r_rotate",       0, 8'h00, 0, 2'd1, 1, 0, 8'h81, 1};
      vecs[5] = '{"r_arith",        0, 8'h00, 0, 2'd2, 1, 0, 8'hC0, 0};
      vecs[6] = '{"l_arith_zero",   0, 8'h00, 1, 2'd2, 1, 1, 8'h80, 1};
      vecs[7] = '{"r_rsvd_logic",   0, 8'h00, 0, 2'd3, 1, 1, 8'hC0, 0};
      vecs[8] = '{"l_logic_si1",    0, 8'h00, 1, 2'd0, 1, 1, 8'h81, 1};
      vecs[9] = '{"load_beats_step",1, 8'h3C, 0, 2'd1, 1, 0, 8'h3C, 0};

      idle_inputs();
      load_data = 0; dir = 0; mode = 0; burst_len = 0; serial_in = 0;
      load_valid2 = 0; load_data2 = 0; dir2 = 0; mode2 = 0; step_en2 = 0;
      burst_start2 = 0; burst_len2 = 0; burst_abort2 = 0; serial_in2 = 0;

      // Reset state
      #12;
      check("rst_po", parallel_out, 8'h00);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ready", load_ready, 1);
      @(negedge clk);
      rst_n = 1;
      tick();

      // Table-driven single-cycle operations
      for (int i = 0; i < 10; i++) begin
         load_valid = vecs[i].lv; load_data = vecs[i].ld; dir = vecs[i].dr;
         mode = vecs[i].md; step_en = vecs[i].st; serial_in = vecs[i].si;
         if (i == 1) check("pre_step_sout", serial_out, 1);
         tick();
         check({vecs[i].name, "_po"}, parallel_out, vecs[i].exp_po);
         check({vecs[i].name, "_sout"}, serial_out, vecs[i].exp_so);
         idle_inputs();
      end

      // Arithmetic burst of 3 from 0x80 with a load attempted during busy
      do_load(8'h80);
      burst_start = 1; burst_len = 3; dir = 0; mode = 2;
      tick();
      burst_start = 0;
      dir = 1; mode = 0;                 // live controls must not affect the running burst
      load_valid = 1; load_data = 8'h55; // must be ignored while busy
      check("ar_sout_latched_dir", serial_out, 0);
      for (int i = 0; i < 3; i++) begin
         check("ar_busy", busy, 1);
         check("ar_ready", load_ready, 0);
         check("ar_done_low", done, 0);
         tick();
      end
      check("ar_po", parallel_out, 8'hF0);
      check("ar_busy_end", busy, 0);
      check("ar_done", done, 1);
      load_valid = 0;
      tick();
      check("ar_done_once", done, 0);
      check("ar_po_hold", parallel_out, 8'hF0);

      // Empty burst
      burst_start = 1; burst_len = 0;
      tick();
      burst_start = 0;
      check("z_done", done, 1);
      check("z_busy", busy, 0);
      check("z_po", parallel_out, 8'hF0);
      tick();
      check("z_done_once", done, 0);
      check("z_busy2", busy, 0);

      // Load and burst_start together: load wins
      load_valid = 1; load_data = 8'h5A; burst_start = 1; burst_len = 2; dir = 0; mode = 0;
      tick();
      idle_inputs();
      check("lb_po", parallel_out, 8'h5A);
      check("lb_busy", busy, 0);
      tick();
      check("lb_busy2", busy, 0);
      check("lb_done", done, 0);
      check("lb_po2", parallel_out, 8'h5A);

      // Abort after 2 of 5 shifts
      do_load(8'h80);
      burst_start = 1; burst_len = 5; dir = 0; mode = 0; serial_in = 0;
      tick();
      burst_start = 0;
      tick();
      tick();
      check("ab_po_mid", parallel_out, 8'h20);
      check("ab_busy_mid", busy, 1);
      burst_abort = 1;
      tick();
      burst_abort = 0;
      check("ab_po", parallel_out, 8'h20);
      check("ab_busy", busy, 0);
      check("ab_done", done, 0);
      check("ab_ready", load_ready, 1);
      tick();
      check("ab_done2", done, 0);

      // Back-to-back: start a new burst in the cycle done is high
      do_load(8'h01);
      burst_start = 1; burst_len = 1; dir = 1; mode = 0; serial_in = 0;
      tick();
      tick();
      check("bb_done1", done, 1);
      check("bb_po1", parallel_out, 8'h02);
      tick();
      burst_start = 0;
      check("bb_busy2", busy, 1);
      check("bb_done_low", done, 0);
      tick();
      check("bb_po2", parallel_out, 8'h04);
      check("bb_done2", done, 1);

      // Reset mid-burst, then a normal step
      do_load(8'hFF);
      burst_start = 1; burst_len = 5; dir = 0; mode = 0; serial_in = 0;
      tick();
      burst_start = 0;
      tick();
      rst_n = 0;
      #1;
      check("mr_po", parallel_out, 8'h00);
      check("mr_busy", busy, 0);
      check("mr_done", done, 0);
      check("mr_ready", load_ready, 1);
      @(negedge clk);
      rst_n = 1;
      step_en = 1; dir = 0; mode = 0; serial_in = 1;
      tick();
      step_en = 0;
      check("mr_step_po", parallel_out, 8'h80);
      check("mr_step_busy", busy, 0);

      // LANE_W=2: fill with 2'b11 over 4 shifts
      load_valid2 = 1; load_data2 = 8'h00;
      tick();
      load_valid2 = 0;
      burst_start2 = 1; burst_len2 = 4; dir2 = 0; mode2 = 0; serial_in2 = 2'b11;
      tick();
      burst_start2 = 0;
      for (int i = 0; i < 4; i++) tick();
      check("l2_fill_po", parallel_out2, 8'hFF);
      check("l2_fill_done", done2, 1);

      // LANE_W=2: serial_out lane sequence from 0xE4
      load_valid2 = 1; load_data2 = 8'hE4; serial_in2 = 2'b00;
      tick();
      load_valid2 = 0;
      burst_start2 = 1; burst_len2 = 4; dir2 = 0; mode2 = 0;
      tick();
      burst_start2 = 0;
      check("l2_sout0", serial_out2, 0);
      for (int i = 1; i < 4; i++) begin
         tick();
         check("l2_sout", serial_out2, i);
      end
      tick();
      check("l2_seq_done", done2, 1);
      check("l2_seq_po", parallel_out2, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
